// File: rtl/cacheline_adaptor_pkg.sv
// Shared constants and types for the L2-line to 64-bit burst adaptor.
// Beat count and counter width are derived from the line/beat widths so
// the datapath scales if either width changes.
package cacheline_adaptor_pkg;

   localparam int S_LINE   = 256;                 // cache line width
   localparam int S_BURST  = 64;                  // memory beat width
   localparam int S_OFFSET = 5;                   // line offset bits
   localparam int BEATS    = S_LINE / S_BURST;    // beats per line
   localparam int CNT_W    = $clog2(BEATS);       // beat counter width

   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Clear the offset bits so the burst always starts on a line boundary.
   function automatic logic [31:0] line_align(input logic [31:0] addr);
      return {addr[31:S_OFFSET], {S_OFFSET{1'b0}}};
   endfunction

endpackage

// File: rtl/cacheline_adaptor.sv
// Converts one 256-bit L2 line read/write into a 4-beat 64-bit burst and
// returns a single-cycle line response. Beat 0 (line bits [63:0]) goes first.
// Minimum latency: request sampled at edge 0, burst in cycles 1-4, resp in 5.
module cacheline_adaptor
   import cacheline_adaptor_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic [31:0]         line_address_i,
   input  logic                line_read_i,
   input  logic                line_write_i,
   input  logic [S_LINE-1:0]   line_wdata_i,
   output logic [S_LINE-1:0]   line_rdata_o,
   output logic                line_resp_o,
   output logic [31:0]         burst_address_o,
   output logic                burst_read_o,
   output logic                burst_write_o,
   output logic [S_BURST-1:0]  burst_wdata_o,
   input  logic [S_BURST-1:0]  burst_rdata_i,
   input  logic                burst_resp_i
);

   state_t              state;
   state_t              state_next;
   logic [CNT_W-1:0]    cnt;
   logic [31:0]         addr_q;
   logic [S_LINE-1:0]   wline_q;
   logic [S_LINE-1:0]   rbuf_q;
   logic [S_LINE-1:0]   rbuf_next;
   logic [S_LINE-1:0]   rline_q;
   logic                latch_req;
   logic                latch_wr;
   logic                beat_adv;
   logic                rd_beat;
   logic                last_beat;

   assign last_beat    = (cnt == LAST_BEAT);
   assign line_rdata_o = rline_q;

   // State register; reset abandons any burst in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode and all burst/line outputs from the current state.
   always_comb begin
      state_next      = state;
      latch_req       = 1'b0;
      latch_wr        = 1'b0;
      beat_adv        = 1'b0;
      rd_beat         = 1'b0;
      burst_read_o    = 1'b0;
      burst_write_o   = 1'b0;
      burst_address_o = '0;
      burst_wdata_o   = '0;
      line_resp_o     = 1'b0;
      case (state)
         IDLE: begin
            // Read wins when both requests arrive together.
            if (line_read_i) begin
               latch_req  = 1'b1;
               state_next = READ;
            end else if (line_write_i) begin
               latch_req  = 1'b1;
               latch_wr   = 1'b1;
               state_next = WRITE;
            end
         end
         READ: begin
            burst_read_o    = 1'b1;
            burst_address_o = addr_q;
            beat_adv        = burst_resp_i;
            rd_beat         = burst_resp_i;
            if (burst_resp_i && last_beat) begin
               state_next = DONE;
            end
         end
         WRITE: begin
            burst_write_o   = 1'b1;
            burst_address_o = addr_q;
            burst_wdata_o   = wline_q[int'(cnt)*S_BURST +: S_BURST];
            beat_adv        = burst_resp_i;
            if (burst_resp_i && last_beat) begin
               state_next = DONE;
            end
         end
         DONE: begin
            // Requests are deliberately not looked at here: the L2 still
            // holds its old request during this cycle.
            line_resp_o = 1'b1;
            state_next  = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Read assembly: current line buffer with the incoming beat dropped into its slot.
   always_comb begin
      rbuf_next = rbuf_q;
      rbuf_next[int'(cnt)*S_BURST +: S_BURST] = burst_rdata_i;
   end

   // Beat counter: cleared on request capture, wraps back to 0 after the last beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (latch_req) begin
         cnt <= '0;
      end else if (beat_adv) begin
         cnt <= cnt + 1'b1;
      end
   end

   // Request capture: address (and write line) held for the whole burst.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q  <= '0;
         wline_q <= '0;
      end else begin
         if (latch_req) begin
            addr_q <= line_align(line_address_i);
         end
         if (latch_wr) begin
            wline_q <= line_wdata_i;
         end
      end
   end

   // Read beats collect in a scratch buffer; the visible line only updates
   // when the final beat lands, so partial reads never leak to the L2.
   always_ff @(posedge clk) begin
      if (rst) begin
         rbuf_q  <= '0;
         rline_q <= '0;
      end else if (rd_beat) begin
         rbuf_q <= rbuf_next;
         if (last_beat) begin
            rline_q <= rbuf_next;
         end
      end
   end

   // Read and write bursts are mutually exclusive by construction.
   assert property (@(posedge clk) disable iff (rst) !(burst_read_o && burst_write_o));

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Scoreboard bench: driver pushes expected line transactions, a memory model
// answers bursts with configurable gaps, and a monitor checks every cycle.
module tb_cacheline_adaptor;
   import cacheline_adaptor_pkg::*;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [31:0]   line_address_i = '0;
   logic          line_read_i = 1'b0;
   logic          line_write_i = 1'b0;
   logic [255:0]  line_wdata_i = '0;
   logic [255:0]  line_rdata_o;
   logic          line_resp_o;
   logic [31:0]   burst_address_o;
   logic          burst_read_o;
   logic          burst_write_o;
   logic [63:0]   burst_wdata_o;
   logic [63:0]   burst_rdata_i = '0;
   logic          burst_resp_i = 1'b0;

   cacheline_adaptor dut (
      .clk             (clk),
      .rst             (rst),
      .line_address_i  (line_address_i),
      .line_read_i     (line_read_i),
      .line_write_i    (line_write_i),
      .line_wdata_i    (line_wdata_i),
      .line_rdata_o    (line_rdata_o),
      .line_resp_o     (line_resp_o),
      .burst_address_o (burst_address_o),
      .burst_read_o    (burst_read_o),
      .burst_write_o   (burst_write_o),
      .burst_wdata_o   (burst_wdata_o),
      .burst_rdata_i   (burst_rdata_i),
      .burst_resp_i    (burst_resp_i)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit           is_rd;
      logic [31:0]  addr;
      logic [255:0] line;
   } exp_t;

   exp_t        exp_q[$];
   logic [63:0] rd_q[$];
   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int gap_mode = 0;     // 0: no gaps, 1: random gaps, 2: 3 idle cycles after beat 1
   int gap_total = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input bit ok, input string name, input string act, input string req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %s required %s", name, act, req);
      end
   endtask

   task automatic finish_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   endtask

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) r = {r[223:0], $urandom()};
      return r;
   endfunction

   // Memory model: answers beats while a burst is requested, optionally stalling.
   int r_beat = 0;
   int r_hold = 0;
   always @(negedge clk) begin
      bit go;
      burst_resp_i  = 1'b0;
      burst_rdata_i = {$urandom(), $urandom()};
      if (!rst && (burst_read_o || burst_write_o)) begin
         case (gap_mode)
            0:       go = 1'b1;
            1:       go = ($urandom_range(0, 2) != 0);
            default: go = !(r_beat == 1 && r_hold < 3);
         endcase
         if (go) begin
            burst_resp_i = 1'b1;
            if (burst_read_o && rd_q.size() > 0) burst_rdata_i = rd_q.pop_front();
            r_beat++;
         end else begin
            gap_total++;
            if (r_beat == 1) r_hold++;
         end
      end else begin
         r_beat = 0;
         r_hold = 0;
      end
   end

   // Monitor: compares every cycle against the head of the expected queue.
   int          m_beat = 0;
   int          m_start = 0;
   int          m_gap0 = 0;
   bit          m_wait = 1'b1;
   logic [255:0] last_rd = '0;
   always @(negedge clk) begin
      exp_t e;
      #1;
      if (rst) begin
         m_beat  = 0;
         m_wait  = 1'b1;
         last_rd = '0;
      end else begin
         chk(!(burst_read_o && burst_write_o), "rd_wr_exclusive",
             $sformatf("%b%b", burst_read_o, burst_write_o), "not both");
         if (burst_read_o || burst_write_o) begin
            if (exp_q.size() == 0) begin
               chk(1'b0, "unexpected_burst", "burst active", "idle");
            end else begin
               e = exp_q[0];
               chk(burst_read_o == e.is_rd, "burst_kind",
                   $sformatf("rd=%b", burst_read_o), $sformatf("rd=%b", e.is_rd));
               chk(burst_address_o == e.addr, "burst_address",
                   $sformatf("%h", burst_address_o), $sformatf("%h", e.addr));
               if (burst_write_o)
                  chk(m_beat < 4 && burst_wdata_o == e.line[(m_beat & 3)*64 +: 64],
                      $sformatf("burst_wdata_beat%0d", m_beat),
                      $sformatf("%h", burst_wdata_o), $sformatf("%h", e.line[(m_beat & 3)*64 +: 64]));
               if (burst_resp_i) m_beat++;
            end
         end else if (line_resp_o) begin
            if (exp_q.size() == 0) begin
               chk(1'b0, "unexpected_resp", "line_resp_o=1", "0");
            end else begin
               e = exp_q.pop_front();
               chk(m_beat == 4, "beats_per_line", $sformatf("%0d", m_beat), "4");
               chk(cyc - m_start == 5 + gap_total - m_gap0, "resp_latency",
                   $sformatf("%0d", cyc - m_start), $sformatf("%0d", 5 + gap_total - m_gap0));
               if (e.is_rd) begin
                  chk(line_rdata_o == e.line, "read_line",
                      $sformatf("%h", line_rdata_o), $sformatf("%h", e.line));
                  last_rd = e.line;
               end else begin
                  chk(line_rdata_o == last_rd, "rdata_hold_on_write",
                      $sformatf("%h", line_rdata_o), $sformatf("%h", last_rd));
               end
            end
            m_beat = 0;
            m_wait = 1'b1;
         end else begin
            chk(burst_address_o == '0 && burst_wdata_o == '0, "idle_outputs_zero",
                $sformatf("%h/%h", burst_address_o, burst_wdata_o), "0/0");
            chk(line_rdata_o == last_rd, "rdata_hold_idle",
                $sformatf("%h", line_rdata_o), $sformatf("%h", last_rd));
            if (m_wait && (line_read_i || line_write_i)) begin
               m_start = cyc;
               m_gap0  = gap_total;
               m_wait  = 1'b0;
            end
         end
      end
   end

   task automatic check_all_zero(input string tag);
      chk(line_resp_o == 1'b0 && burst_read_o == 1'b0 && burst_write_o == 1'b0,
          {tag, "_ctrl_zero"}, $sformatf("%b%b%b", line_resp_o, burst_read_o, burst_write_o), "000");
      chk(burst_address_o == '0 && burst_wdata_o == '0, {tag, "_bus_zero"},
          $sformatf("%h/%h", burst_address_o, burst_wdata_o), "0/0");
      chk(line_rdata_o == '0, {tag, "_rdata_zero"}, $sformatf("%h", line_rdata_o), "0");
   endtask

   // Issue one line request (caller is at a negedge) and wait for its response.
   task automatic txn(input bit rd, input bit wr, input logic [31:0] addr,
                      input logic [255:0] wd, input logic [255:0] rl,
                      input int mode, input bit b2b);
      exp_t e;
      int   n;
      bit   got;
      gap_mode = mode;
      e.is_rd = rd;
      e.addr  = addr & ~32'h1f;
      e.line  = rd ? rl : wd;
      exp_q.push_back(e);
      if (rd) for (int k = 0; k < 4; k++) rd_q.push_back(rl[k*64 +: 64]);
      line_read_i    = rd;
      line_write_i   = wr;
      line_address_i = addr;
      line_wdata_i   = wd;
      n = 0;
      got = 1'b0;
      while (n < 300 && !got) begin
         @(negedge clk);
         n++;
         if (line_resp_o) got = 1'b1;
      end
      if (!got) begin
         chk(1'b0, "resp_timeout", "no line_resp_o", "line_resp_o within 300 cycles");
         finish_run();
      end
      if (!b2b) begin
         @(posedge clk);
         #1;
         line_read_i    = 1'b0;
         line_write_i   = 1'b0;
         line_address_i = $urandom();
         line_wdata_i   = rand256();
         @(negedge clk);
      end
   endtask

   initial begin
      #1000000;
      chk(1'b0, "watchdog", "time limit reached", "finish");
      finish_run();
   end

   initial begin
      int kind;
      int cnt2;
      int n;
      logic [255:0] l;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Read, back-to-back beats
      txn(1'b1, 1'b0, 32'h0000_1234, rand256(),
          {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
           64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 0, 1'b0);
      // Write with random memory stalls
      txn(1'b0, 1'b1, 32'h8000_00E0,
          {64'hD3D3_0000_0000_0003, 64'hD2D2_0000_0000_0002,
           64'hD1D1_0000_0000_0001, 64'hD0D0_0000_0000_0000}, '0, 1, 1'b0);
      // Stalled read: three idle cycles between beats 1 and 2
      txn(1'b1, 1'b0, $urandom(), rand256(), rand256(), 2, 1'b0);
      // Simultaneous read and write: read wins
      txn(1'b1, 1'b1, $urandom(), rand256(), rand256(), 1, 1'b0);
      // Back-to-back: write, next request raised during DONE, then read
      txn(1'b0, 1'b1, $urandom(), rand256(), '0, 0, 1'b1);
      txn(1'b1, 1'b0, $urandom(), rand256(), rand256(), 0, 1'b0);

      // Randomized traffic
      for (int t = 0; t < 40; t++) begin
         kind = $urandom_range(0, 2);
         txn(kind != 1, kind != 0, $urandom(), rand256(), rand256(),
             $urandom_range(0, 2), $urandom_range(0, 1) == 1);
         if (!line_read_i && !line_write_i) repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      // Make sure no request is left pending from a back-to-back tail
      txn(1'b0, 1'b1, $urandom(), rand256(), '0, 0, 1'b0);

      // Reset mid-burst after two read beats
      begin
         exp_t e;
         l = rand256();
         gap_mode = 0;
         e.is_rd = 1'b1;
         e.addr  = 32'h0000_4440;
         e.line  = l;
         exp_q.push_back(e);
         for (int k = 0; k < 4; k++) rd_q.push_back(l[k*64 +: 64]);
         line_read_i    = 1'b1;
         line_address_i = 32'h0000_445C;
         cnt2 = 0;
         n = 0;
         while (cnt2 < 2 && n < 100) begin
            @(negedge clk);
            #2;
            if (burst_read_o && burst_resp_i) cnt2++;
            n++;
         end
         chk(cnt2 == 2, "reset_test_two_beats", $sformatf("%0d", cnt2), "2");
         @(posedge clk);
         #1;
         rst = 1'b1;
         line_read_i = 1'b0;
         @(posedge clk);
         #1;
         rst = 1'b0;
         exp_q.delete();
         rd_q.delete();
         check_all_zero("mid_burst_reset");
         @(negedge clk);
         chk(line_resp_o == 1'b0, "no_resp_after_abort", $sformatf("%b", line_resp_o), "0");
      end

      // A fresh read after the abort must complete normally
      txn(1'b1, 1'b0, $urandom(), rand256(), rand256(), 1, 1'b0);
      repeat (3) @(negedge clk);
      chk(exp_q.size() == 0, "scoreboard_drained", $sformatf("%0d", exp_q.size()), "0");
      finish_run();
   end

endmodule

// File: doc/cacheline_adaptor.md
Name: cacheline_adaptor

Overview:
Sits directly downstream of the L2 cache, between its line-wide pmem interface and the 64-bit burst physical memory. It converts one 256-bit line read or write into a 4-beat burst transaction. It presents a single-cycle line response back to the L2.

Parameters:
s_line, 256, cache line width in bits (must match the L2 line width)
s_burst, 64, physical memory beat width in bits
s_offset, 5, line offset bits; the burst address is line-aligned by forcing these bits to 0

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
line_address_i  input  32  line address from L2 (pmem_address)
line_read_i  input  1  line read request from L2
line_write_i  input  1  line write request from L2
line_wdata_i  input  s_line  line to write (pmem_wdata)
line_rdata_o  output  s_line  assembled read line (to L2 pmem_rdata)
line_resp_o  output  1  one-cycle completion pulse (to L2 pmem_resp)
burst_address_o  output  32  line-aligned burst address
burst_read_o  output  1  burst read request
burst_write_o  output  1  burst write request
burst_wdata_o  output  s_burst  current write beat
burst_rdata_i  input  s_burst  read beat from memory
burst_resp_i  input  1  beat accepted (write) or beat valid (read)

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Derived constant: BEATS = s_line/s_burst = 4. Beat counter is 2 bits wide.
- Beat k carries line bits [64k+63:64k]. Beat 0 is transferred first.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - All burst outputs are 0; line_resp_o = 0.
  - If line_read_i is high: latch {line_address_i[31:5], 5'b0}, clear the counter, go to READ.
  - Else if line_write_i is high: latch the address and line_wdata_i, clear the counter, go to WRITE.
  - Read has priority if both requests are high in the same cycle.
  - burst_resp_i is ignored.
- READ:
  - burst_read_o = 1; burst_address_o = latched address.
  - Each cycle with burst_resp_i = 1, store burst_rdata_i into slot[counter] and increment the counter.
  - Cycles with burst_resp_i = 0 stall with no change; gaps between beats are legal.
  - When the 4th beat arrives (counter == 3 and burst_resp_i = 1), go to DONE.
- WRITE:
  - burst_write_o = 1; burst_address_o = latched address; burst_wdata_o = latched line beat[counter], driven combinationally from the counter.
  - Each burst_resp_i pulse advances the counter.
  - The 4th response goes to DONE.
- DONE:
  - line_resp_o = 1 for exactly one cycle; burst_read_o and burst_write_o are 0.
  - New requests are not sampled in this cycle. Always return to IDLE next.
  - The L2 drops its request on the edge that samples line_resp_o.
- line_rdata_o is registered. It holds the last completed read line until the next read completes. Writes do not modify it.
- Minimum latency, with memory responding every cycle:
  - request sampled at edge 0;
  - burst request high in cycles 1–4;
  - line_resp_o high in cycle 5.
- burst_read_o and burst_write_o are never high together.
- Request inputs are not re-sampled mid-transaction; latched address and data are used throughout.
- Reset:
  - rst overrides everything, including mid-burst.
  - Next cycle: state = IDLE, counter = 0, line_rdata_o = 0, all outputs 0.
  - A partial burst is abandoned with no line_resp_o.

Decomposition:
- Package cacheline_adaptor_pkg holds:
  - the state enum (IDLE, READ, WRITE, DONE);
  - BEATS and the beat-counter width, both derived from s_line/s_burst.
- No sub-module. A single FSM plus counter plus line register is natural. Beat select and insert are indexed part-selects.

Test Plan:
- Read, back-to-back beats: line_read_i with address 0x0000_1234; memory returns 0x11..11, 0x22..22, 0x33..33, 0x44..44 → burst_address_o = 0x0000_1220; one line_resp_o pulse in cycle 5; line_rdata_o = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- Write: line_wdata_i = {D3,D2,D1,D0}, address 0x8000_00E0 → burst_wdata_o sequence is D0, D1, D2, D3, each held until its burst_resp_i; exactly one line_resp_o after the 4th response.
- Stalled read: burst_resp_i has 3 idle cycles between beats 1 and 2 → correct line assembled; burst_read_o stays high throughout; line_resp_o in cycle 8.
- Simultaneous line_read_i and line_write_i → READ taken; burst_write_o never asserted.
- Reset mid-burst: rst asserted after 2 read beats → next cycle all outputs 0 and line_rdata_o = 0; a following read completes normally with fresh data.
- Back-to-back requests: a write immediately followed by a read, requests held until resp → no request sampled during DONE; the read's burst starts in the cycle after IDLE samples it.
